// File: rtl/iterst_pkg.sv
// Shared defaults, types and the step function for the iterated-state scheduler.
package iterst_pkg;

    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 1;
    localparam int unsigned LW   = $clog2(NREQ);

    typedef logic [LW-1:0] lane_t;
    typedef logic [W-1:0]  word_t;

    function automatic word_t iterst_step(word_t st, word_t in);
        return st ^ in;
    endfunction

endpackage

// File: rtl/iterst_sched_if.sv
// Request/result bundle between producers, the scheduler and the consumer.
interface iterst_sched_if
    import iterst_pkg::*;
#(
    parameter int unsigned NREQ = iterst_pkg::NREQ,
    parameter int unsigned W    = iterst_pkg::W
);
    localparam int unsigned LW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   req_clr;
    logic [NREQ-1:0]   req_ready;
    logic              out_valid;
    logic [W-1:0]      out_data;
    logic [LW-1:0]     out_lane;
    logic              out_ready;

    // Producer/consumer side.
    modport master (
        output req_valid, req_data, req_clr, out_ready,
        input  req_ready, out_valid, out_data, out_lane
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_data, req_clr, out_ready,
        output req_ready, out_valid, out_data, out_lane
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requesting lane at or after ptr wins.
module rr_arbiter
    import iterst_pkg::*;
#(
    parameter int unsigned NREQ = iterst_pkg::NREQ,
    localparam int unsigned LW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [LW-1:0]   ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [LW-1:0]   idx,
    output logic            any
);

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        // Visit lanes in priority order ptr, ptr+1, ... and keep the first hit.
        for (int unsigned k = 0; k < NREQ; k++) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (en && !any && req[i] && ((32'(ptr) + k) % NREQ == i)) begin
                    gnt[i] = 1'b1;
                    idx    = LW'(i);
                    any    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/iterst_sched.sv
// Round-robin scheduler sharing one XOR step unit across NREQ lanes with
// per-lane state and a single registered, lane-tagged result stream.
module iterst_sched
    import iterst_pkg::*;
#(
    parameter int unsigned NREQ = iterst_pkg::NREQ,
    parameter int unsigned W    = iterst_pkg::W
) (
    input logic           clk,
    input logic           rst,
    iterst_sched_if.slave bus
);

    localparam int unsigned    LW       = $clog2(NREQ);
    localparam logic [LW-1:0]  LastLane = LW'(NREQ - 1);

    logic [NREQ-1:0][W-1:0] stQ, stD, dataArr;
    logic [LW-1:0]          ptrQ, ptrD, gIdx, outLaneQ, outLaneD;
    logic                   outValidQ, outValidD;
    logic [W-1:0]           outDataQ, outDataD, base, res;
    logic                   canIssue, arbEn, grant;
    logic [NREQ-1:0]        gnt;

    assign dataArr  = bus.req_data;
    assign canIssue = !outValidQ || bus.out_ready;
    // Reset gates the grant so no lane sees ready while rst is high.
    assign arbEn    = canIssue && !rst;

    rr_arbiter #(
        .NREQ (NREQ)
    ) uArb (
        .req (bus.req_valid),
        .ptr (ptrQ),
        .en  (arbEn),
        .gnt (gnt),
        .idx (gIdx),
        .any (grant)
    );

    assign bus.req_ready = gnt;

    // Clear-then-step when the granted lane is also being cleared.
    assign base = bus.req_clr[gIdx] ? '0 : stQ[gIdx];
    assign res  = iterst_step(base, dataArr[gIdx]);

    always_comb begin
        stD       = stQ;
        ptrD      = ptrQ;
        outValidD = outValidQ;
        outDataD  = outDataQ;
        outLaneD  = outLaneQ;

        for (int unsigned i = 0; i < NREQ; i++) begin
            if (bus.req_clr[i]) stD[i] = '0;
        end

        if (grant) begin
            stD[gIdx] = res;
            outValidD = 1'b1;
            outDataD  = res;
            outLaneD  = gIdx;
            ptrD      = (gIdx == LastLane) ? '0 : gIdx + LW'(1);
        end else if (canIssue) begin
            outValidD = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stQ       <= '0;
            ptrQ      <= '0;
            outValidQ <= 1'b0;
            outDataQ  <= '0;
            outLaneQ  <= '0;
        end else begin
            stQ       <= stD;
            ptrQ      <= ptrD;
            outValidQ <= outValidD;
            outDataQ  <= outDataD;
            outLaneQ  <= outLaneD;
        end
    end

    assign bus.out_valid = outValidQ;
    assign bus.out_data  = outDataQ;
    assign bus.out_lane  = outLaneQ;

endmodule
